// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: frame sequencer for a streaming FFT core.
//
// This block collects ADC samples into frames of FFT_LEN beats. It drives the
// core's AXI4-Stream data input, issues one config beat per frame, waits for
// the core's output frame, and then re-arms.
//
// Optional feature: define FFT_TIMEOUT_EN to add a watchdog in WAIT_OUT.
// In the default build, WAIT_OUT waits indefinitely and timeout_err is 0.
//
// Handshake semantics (m_* data port): a beat transfers on every rising edge
// of fft_clk where m_tvalid && m_tready. Once m_tvalid is raised, it stays high
// and m_tdata/m_tlast stay stable until that beat transfers. m_tvalid is high
// only in LOAD. m_tready is never used to gate m_tvalid.
//
// fsm_state exposes the controller state for checkers:
// 0 IDLE, 1 CFG, 2 LOAD, 3 WAIT_OUT, 4 HOLD.

module fft_frame_ctrl #(
    parameter int FFT_LEN     = 256,
    parameter int DATA_W      = 8,
    parameter int HOLDOFF     = 16,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic              fft_clk,
    input  logic              rst_n,
    input  logic              fft_en,
    input  logic              cont_mode,
    input  logic [DATA_W-1:0] ad_data_in,
    output logic              m_tvalid,
    output logic [31:0]       m_tdata,
    output logic              m_tlast,
    input  logic              m_tready,
    output logic              cfg_tvalid,
    output logic              cfg_tdata,
    input  logic              s_tvalid,
    input  logic              s_tlast,
    output logic              busy,
    output logic              frame_done,
    output logic              stall_err,
    output logic              timeout_err,
    output logic [2:0]        fsm_state
);

    // Reject parameter sets the counters below cannot represent.
    if ((FFT_LEN & (FFT_LEN - 1)) != 0 || FFT_LEN < 8 || FFT_LEN > 1024 ||
        DATA_W < 1 || DATA_W > 32 || HOLDOFF < 1 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("fft_frame_ctrl: illegal parameter value");
    end

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CFG      = 3'd1,
        ST_LOAD     = 3'd2,
        ST_WAIT_OUT = 3'd3,
        ST_HOLD     = 3'd4
    } state_t;

    localparam int CNT_W  = $clog2(FFT_LEN);
    localparam int HOLD_W = $clog2(HOLDOFF + 1);

    // Beat index of the final beat, and of the beat just before it. m_tlast is
    // registered, so it is raised when the counter steps onto LAST_IDX.
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(FFT_LEN - 1);
    localparam logic [CNT_W-1:0]  PRE_LAST = CNT_W'(FFT_LEN - 2);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLDOFF);

    state_t            state;
    logic [CNT_W-1:0]  beat_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              fft_en_q;
    logic              start_req;

`ifdef FFT_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    logic [TO_W-1:0] to_cnt;
`else
    assign timeout_err = 1'b0;
`endif

    assign fsm_state = state;

    // Frame start request.
    // Continuous mode is level-triggered on fft_en.
    // Single-shot mode needs a fresh 0->1 edge of fft_en.
    always_comb begin
        start_req = 1'b0;
        if (cont_mode) begin
            start_req = fft_en;
        end else begin
            start_req = fft_en & ~fft_en_q;
        end
    end

    // Frame sequencer: state, counters, registered stream outputs and sticky flags.
    always_ff @(posedge fft_clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            beat_cnt   <= '0;
            hold_cnt   <= '0;
            fft_en_q   <= 1'b0;
            m_tvalid   <= 1'b0;
            m_tdata    <= '0;
            m_tlast    <= 1'b0;
            cfg_tvalid <= 1'b0;
            cfg_tdata  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            stall_err  <= 1'b0;
`ifdef FFT_TIMEOUT_EN
            to_cnt      <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            fft_en_q   <= fft_en;
            cfg_tvalid <= 1'b0;
            cfg_tdata  <= 1'b0;
            frame_done <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (start_req) begin
                        state      <= ST_CFG;
                        cfg_tvalid <= 1'b1;
                        cfg_tdata  <= 1'b1;
                        busy       <= 1'b1;
                    end
                end

                // The config beat has been presented for one cycle.
                // Present the first sample now.
                ST_CFG: begin
                    state    <= ST_LOAD;
                    m_tvalid <= 1'b1;
                    m_tdata  <= 32'(ad_data_in);
                    m_tlast  <= 1'b0;
                    beat_cnt <= '0;
                end

                // m_tvalid is always high here, so m_tready alone marks a transfer.
                ST_LOAD: begin
                    if (m_tready) begin
                        if (beat_cnt == LAST_IDX) begin
                            state    <= ST_WAIT_OUT;
                            m_tvalid <= 1'b0;
                            m_tlast  <= 1'b0;
                            beat_cnt <= '0;
`ifdef FFT_TIMEOUT_EN
                            to_cnt   <= '0;
`endif
                        end else begin
                            beat_cnt <= beat_cnt + CNT_W'(1);
                            m_tdata  <= 32'(ad_data_in);
                            m_tlast  <= (beat_cnt == PRE_LAST);
                        end
                    end else begin
                        // The current beat stays on the bus.
                        // The sample arriving this cycle is lost.
                        stall_err <= 1'b1;
                    end
                end

                ST_WAIT_OUT: begin
                    if (s_tvalid && s_tlast) begin
                        state      <= ST_HOLD;
                        frame_done <= 1'b1;
                        hold_cnt   <= '0;
                    end
`ifdef FFT_TIMEOUT_EN
                    else if (to_cnt == TO_LAST) begin
                        state       <= ST_HOLD;
                        timeout_err <= 1'b1;
                        hold_cnt    <= '0;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
`endif
                end

                // The frame_done cycle counts as hold count 0.
                // HOLDOFF idle cycles then follow before the next config beat.
                ST_HOLD: begin
                    if (hold_cnt == HOLD_MAX) begin
                        if (fft_en && cont_mode) begin
                            state      <= ST_CFG;
                            cfg_tvalid <= 1'b1;
                            cfg_tdata  <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end

                default: begin
                    state    <= ST_IDLE;
                    busy     <= 1'b0;
                    m_tvalid <= 1'b0;
                    m_tlast  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb_fft_frame_ctrl: directed plus randomized bench for fft_frame_ctrl.
// The bench keeps a transaction-level model of the stream.
// Each new beat carries the sample present at the edge where the previous
// beat transferred, or at the edge where valid rose. There are exactly
// FFT_LEN transfers per frame, and tlast marks the final transfer.
// frame_done follows s_tlast only while the model is awaiting core output.

module tb_fft_frame_ctrl;

    localparam int FFT_LEN     = 256;
    localparam int HOLDOFF     = 16;
    localparam int TIMEOUT_CYC = 64;

    logic        fft_clk;
    logic        rst_n;
    logic        fft_en;
    logic        cont_mode;
    logic [7:0]  ad_data_in;
    logic        m_tvalid;
    logic [31:0] m_tdata;
    logic        m_tlast;
    logic        m_tready;
    logic        cfg_tvalid;
    logic        cfg_tdata;
    logic        s_tvalid;
    logic        s_tlast;
    logic        busy;
    logic        frame_done;
    logic        stall_err;
    logic        timeout_err;
    logic [2:0]  fsm_state;

    fft_frame_ctrl #(
        .FFT_LEN(FFT_LEN), .DATA_W(8), .HOLDOFF(HOLDOFF), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .fft_clk(fft_clk), .rst_n(rst_n), .fft_en(fft_en), .cont_mode(cont_mode),
        .ad_data_in(ad_data_in), .m_tvalid(m_tvalid), .m_tdata(m_tdata),
        .m_tlast(m_tlast), .m_tready(m_tready), .cfg_tvalid(cfg_tvalid),
        .cfg_tdata(cfg_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
        .busy(busy), .frame_done(frame_done), .stall_err(stall_err),
        .timeout_err(timeout_err), .fsm_state(fsm_state)
    );

    // Clock and run-time limit.
    initial begin
        fft_clk = 1'b0;
        forever #5 fft_clk = ~fft_clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // Counters and model state.
    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [31:0] exp_q[$];
    int   beat_cnt   = 0;
    int   total_acc  = 0;
    int   frames_in  = 0;
    int   n_done     = 0;
    int   n_cfg      = 0;
    int   wait_cnt   = 0;
    int   fin_cyc    = 0;
    int   done_cyc   = 0;
    int   cfg_cyc    = 0;
    logic prev_valid = 1'b0;
    logic prev_cfg   = 1'b0;
    logic awaiting   = 1'b0;
    logic exp_stall  = 1'b0;
    logic exp_to     = 1'b0;
    logic ramp_on    = 1'b0;
    logic [7:0] ramp_val = 8'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock. Score the outputs 1 time unit after the edge.
    // Then drive the inputs for the next edge.
    task automatic step(input logic rdy);
        logic [7:0] d;
        logic r, rs, sv, sl, acc, fin, exp_done;
        d  = ad_data_in;
        r  = m_tready;
        rs = rst_n;
        sv = s_tvalid;
        sl = s_tlast;
        @(posedge fft_clk);
        #1;
        cyc++;
        if (!rs) begin
            exp_q.delete();
            beat_cnt   = 0;
            prev_valid = 1'b0;
            prev_cfg   = 1'b0;
            awaiting   = 1'b0;
            exp_stall  = 1'b0;
            exp_to     = 1'b0;
            check("rst_m_tvalid", m_tvalid, 0);
            check("rst_m_tlast", m_tlast, 0);
            check("rst_m_tdata", m_tdata, 0);
            check("rst_cfg_tvalid", cfg_tvalid, 0);
            check("rst_busy", busy, 0);
            check("rst_frame_done", frame_done, 0);
            check("rst_stall_err", stall_err, 0);
            check("rst_timeout_err", timeout_err, 0);
        end else begin
            acc = prev_valid && r;
            fin = 1'b0;
            if (prev_valid && !r) exp_stall = 1'b1;
            if (acc) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                beat_cnt++;
                total_acc++;
                if (beat_cnt == FFT_LEN) begin
                    fin       = 1'b1;
                    beat_cnt  = 0;
                    frames_in++;
                    fin_cyc   = cyc;
                end
            end
            exp_done = awaiting && sv && sl;
            if (exp_done) begin
                awaiting = 1'b0;
            end else if (awaiting) begin
                wait_cnt++;
`ifdef FFT_TIMEOUT_EN
                if (wait_cnt == TIMEOUT_CYC) begin
                    awaiting = 1'b0;
                    exp_to   = 1'b1;
                end
`endif
            end
            if (fin) begin
                awaiting = 1'b1;
                wait_cnt = 0;
                check("valid_after_last", m_tvalid, 0);
            end
            if (m_tvalid && (!prev_valid || acc)) exp_q.push_back({24'd0, d});
            if (m_tvalid) begin
                check("beat_pending", exp_q.size(), 1);
                if (exp_q.size() > 0) check("m_tdata", m_tdata, exp_q[0]);
                check("m_tlast", m_tlast, (beat_cnt == FFT_LEN - 1));
                check("busy_in_load", busy, 1);
            end else begin
                check("m_tlast_idle", m_tlast, 0);
            end
            check("frame_done", frame_done, exp_done);
            if (frame_done) begin
                n_done++;
                done_cyc = cyc;
            end
            check("stall_err", stall_err, exp_stall);
            check("timeout_err", timeout_err, exp_to);
            if (cfg_tvalid) begin
                n_cfg++;
                cfg_cyc = cyc;
                check("cfg_tdata", cfg_tdata, 1);
                check("cfg_single_cycle", prev_cfg, 0);
            end
            prev_cfg   = cfg_tvalid;
            prev_valid = m_tvalid;
        end
        m_tready = rdy;
        if (ramp_on) begin
            ad_data_in = ramp_val;
            ramp_val   = ramp_val + 8'd1;
        end else begin
            ad_data_in = 8'($urandom);
        end
    endtask

    task automatic wait_beats(input int n, input int limit);
        for (int i = 0; i < limit && beat_cnt < n; i++) step(1'b1);
        check("wait_beats_reached", beat_cnt, n);
    endtask

    task automatic wait_frame_in(input int limit);
        int start;
        start = frames_in;
        for (int i = 0; i < limit && frames_in == start; i++) step(1'b1);
        check("frame_in_complete", frames_in, start + 1);
    endtask

    task automatic core_done_after(input int delay);
        int start;
        start = n_done;
        repeat (delay - 1) step(1'b1);
        s_tvalid = 1'b1;
        s_tlast  = 1'b1;
        step(1'b1);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        check("frame_done_count", n_done, start + 1);
    endtask

    int c0;
    int acc0;
    int load_start;

    initial begin
        rst_n      = 1'b0;
        fft_en     = 1'b0;
        cont_mode  = 1'b0;
        m_tready   = 1'b1;
        s_tvalid   = 1'b0;
        s_tlast    = 1'b0;
        ad_data_in = 8'd0;
        repeat (3) step(1'b1);

        // Single frame, ramp data, m_tready held high.
        rst_n    = 1'b1;
        fft_en   = 1'b1;
        ramp_on  = 1'b1;
        ramp_val = 8'd0;
        step(1'b1);
        check("t1_cfg_pulse", cfg_tvalid, 1);
        check("t1_busy", busy, 1);
        check("t1_valid_not_yet", m_tvalid, 0);
        step(1'b1);
        load_start = cyc;
        check("t1_valid_latency", m_tvalid, 1);
        check("t1_first_beat", m_tdata, 0);
        acc0 = total_acc;
        wait_frame_in(FFT_LEN + 10);
        check("t1_load_cycles", fin_cyc - load_start, FFT_LEN);
        check("t1_beats", total_acc - acc0, FFT_LEN);
        core_done_after(300);
        repeat (40) step(1'b1);
        check("t1_single_cfg", n_cfg, 1);
        check("t1_idle_busy", busy, 0);

        // Continuous mode, random data, stall near beat 100, s_* ignored in LOAD.
        ramp_on   = 1'b0;
        cont_mode = 1'b1;
        s_tvalid  = 1'b1;
        s_tlast   = 1'b1;
        acc0      = total_acc;
        wait_beats(100, 200);
        s_tvalid  = 1'b0;
        s_tlast   = 1'b0;
        repeat (5) step(1'b0);
        step(1'b1);
        check("t2_stall_flag", stall_err, 1);
        wait_frame_in(FFT_LEN + 10);
        check("t2_beats", total_acc - acc0, FFT_LEN);
        check("t2_no_early_done", n_done, 1);
        c0 = n_cfg;
        core_done_after(300);
        for (int i = 0; i < 40 && n_cfg == c0; i++) step(1'b1);
        check("t2_rearm_cfg", n_cfg, c0 + 1);
        check("t2_rearm_delay", cfg_cyc - done_cyc, HOLDOFF + 1);

        // fft_en drops mid-frame; the frame still completes, then IDLE.
        wait_beats(50, 100);
        fft_en = 1'b0;
        acc0   = total_acc;
        c0     = n_cfg;
        wait_frame_in(FFT_LEN + 10);
        check("t3_beats_rest", total_acc - acc0, FFT_LEN - 50);
        core_done_after(10);
        repeat (40) step(1'b1);
        check("t3_busy_low", busy, 0);
        check("t3_no_new_cfg", n_cfg, c0);

        // Reset at beat 128 abandons the frame and clears the sticky flags.
        cont_mode = 1'b0;
        fft_en    = 1'b1;
        wait_beats(128, 200);
        rst_n  = 1'b0;
        fft_en = 1'b0;
        step(1'b1);
        check("t4_valid_dropped", m_tvalid, 0);
        check("t4_stall_cleared", stall_err, 0);
        rst_n = 1'b1;
        repeat (5) step(1'b1);
        check("t4_idle_busy", busy, 0);

        // The core never returns s_tlast.
        fft_en = 1'b1;
        c0     = n_done;
        wait_frame_in(FFT_LEN + 10);
`ifdef FFT_TIMEOUT_EN
        repeat (TIMEOUT_CYC + 2) step(1'b1);
        check("t5_timeout_flag", timeout_err, 1);
        check("t5_no_done", n_done, c0);
`else
        repeat (200) step(1'b1);
        check("t5_still_waiting", busy, 1);
        check("t5_no_done", n_done, c0);
        core_done_after(5);
`endif
        fft_en = 1'b0;
        repeat (30) step(1'b1);
        check("t5_final_idle", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fft_frame_ctrl.md
Name: fft_frame_ctrl

Overview:
Sequences the streaming FFT core on the fft_clk domain. Captures 8-bit ADC samples into fixed-length frames and drives the core's AXI4-Stream data input with a full valid/ready handshake and tlast. Issues the core's config beat once per frame, waits for the complete output frame, then re-arms in single-shot or continuous mode. Sits between the ADC sample bus and the FFT core input; the FFT core itself is outside this block.

Parameters:
FFT_LEN, 256, samples per frame; power of two, 8..1024
DATA_W, 8, ADC sample width; zero-extended to 32 bits on m_tdata
HOLDOFF, 16, idle cycles between frame_done and next frame start; >=1
TIMEOUT_CYC, 4096, watchdog limit in WAIT_OUT (used only with FFT_TIMEOUT_EN)

Ports:
fft_clk  in  1  clock, all logic on rising edge
rst_n  in  1  reset, synchronous, active-low
fft_en  in  1  level enable; frame may start only while high
cont_mode  in  1  1 = re-arm automatically after HOLD; 0 = single frame per fft_en rising edge
ad_data_in  in  DATA_W  ADC sample, new value every cycle
m_tvalid  out  1  to core i_axi4s_data_tvalid
m_tdata  out  32  to core i_axi4s_data_tdata, {zeros, sample}
m_tlast  out  1  to core i_axi4s_data_tlast
m_tready  in  1  from core o_axi4s_data_tready
cfg_tvalid  out  1  to core i_axi4s_cfg_tvalid
cfg_tdata  out  1  to core i_axi4s_cfg_tdata; 1 = forward FFT
s_tvalid  in  1  core output valid
s_tlast  in  1  core output last
busy  out  1  high in any state except IDLE
frame_done  out  1  one-cycle pulse when core output frame completes
stall_err  out  1  sticky; set if any sample was dropped while m_tready low
timeout_err  out  1  sticky watchdog flag (0 when feature is off)

Behaviour:
- Reset (rst_n=0 at clock edge): state IDLE; all outputs 0; counters 0; sticky flags cleared. Reset mid-frame abandons the frame immediately; m_tvalid drops on the next edge.
- States: IDLE, CFG, LOAD, WAIT_OUT, HOLD.
- IDLE -> CFG on fft_en=1 (cont_mode=1), or on a detected fft_en 0->1 edge (cont_mode=0).
- CFG: cfg_tvalid=1, cfg_tdata=1 for exactly one cycle -> LOAD.
- LOAD: m_tvalid=1. m_tdata loads {0, ad_data_in} on entry and on each cycle where a beat is accepted (m_tvalid && m_tready). During a stall m_tdata is held stable; samples arriving meanwhile are discarded and stall_err is set.
- Sample counter increments per accepted beat. m_tlast=1 exactly while the counter equals FFT_LEN-1.
- When the last beat is accepted -> WAIT_OUT; m_tvalid and m_tlast are 0 on the next cycle. Accepted beats per frame are always exactly FFT_LEN.
- fft_en falling during LOAD does not truncate the frame; the frame completes and the FSM then returns to IDLE via WAIT_OUT/HOLD.
- WAIT_OUT: on s_tvalid && s_tlast, pulse frame_done for 1 cycle -> HOLD.
- HOLD: count HOLDOFF cycles, then -> CFG if fft_en && cont_mode, else -> IDLE.
- Latency: m_tvalid rises 2 cycles after the IDLE exit condition is sampled. With m_tready held high, LOAD lasts exactly FFT_LEN cycles.
- s_tvalid/s_tlast are ignored in all states except WAIT_OUT.

Optional Feature:
FFT_TIMEOUT_EN: when defined, a WAIT_OUT cycle counter runs. If it reaches TIMEOUT_CYC without s_tlast, timeout_err is set (sticky) and the FSM goes to HOLD with no frame_done pulse. When not defined, there is no counter, timeout_err is tied to 0, and WAIT_OUT waits indefinitely.

Test Plan:
- Reset, fft_en=1, cont_mode=0, m_tready=1, ramp data -> cfg_tvalid one pulse; 256 beats carrying 0..255 in m_tdata[7:0]; m_tlast only on beat 256; busy=1.
- m_tready low for 5 cycles at beat 100 -> m_tdata held for those cycles, stall_err=1, total accepted beats still 256.
- Core returns s_tlast 300 cycles after the last input beat -> frame_done pulses once; 16 HOLD cycles; cont_mode=1 gives a second cfg pulse on cycle 17 after frame_done.
- fft_en dropped at beat 50 -> frame still completes 256 beats, then IDLE; busy=0; no new cfg pulse.
- rst_n asserted at beat 128 -> next edge: m_tvalid=0, state IDLE, stall_err cleared.
- With FFT_TIMEOUT_EN, TIMEOUT_CYC=64, no s_tlast -> timeout_err=1 after 64 WAIT_OUT cycles; no frame_done pulse.
